// File: rtl/lfsr_pkg.sv
// Shared definitions for the 16-bit Fibonacci LFSR generator/checker pair.
// Polynomial taps 15, 14, 12, 3 with left shift; feedback enters at bit 0.
package lfsr_pkg;

    localparam int LFSR_W = 16;

    // Tap positions feeding the XOR that becomes the new bit 0
    localparam int TAP_A = 15;
    localparam int TAP_B = 14;
    localparam int TAP_C = 12;
    localparam int TAP_D = 3;

    // Sequence start word, also used as the period marker by the checker
    localparam logic [LFSR_W-1:0] LFSR_SEED_DEFAULT = 16'h026E;

    // Checker lock state
    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } chk_state_e;

    // Next LFSR state; the generator and the checker both use this so the
    // polynomial cannot drift between the two ends of the link.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], s[TAP_A] ^ s[TAP_B] ^ s[TAP_C] ^ s[TAP_D]};
    endfunction

endpackage

// File: rtl/lfsr_checker_if.sv
// Receive-side bus of the LFSR checker: word stream in, lock/error status out.
interface lfsr_checker_if #(
    parameter int ERR_W = 16
);
    logic                         in_valid;
    logic [lfsr_pkg::LFSR_W-1:0]  in_word;
    logic                         clr_count;
    logic                         locked;
    logic                         err_pulse;
    logic [ERR_W-1:0]             err_count;
    logic                         period_tick;

    // Word source / status consumer side
    modport master (
        output in_valid, in_word, clr_count,
        input  locked, err_pulse, err_count, period_tick
    );

    // Checker side
    modport slave (
        input  in_valid, in_word, clr_count,
        output locked, err_pulse, err_count, period_tick
    );
endinterface

// File: rtl/lfsr_predict.sv
// Combinational predictor: next expected word from the previous received
// word, and the match decision. An all-zero word never matches because it is
// the LFSR lock-up state and cannot occur in a healthy stream.
module lfsr_predict
    import lfsr_pkg::*;
(
    input  logic [LFSR_W-1:0] prev,
    input  logic [LFSR_W-1:0] word,
    output logic              match
);
    logic [LFSR_W-1:0] pred;

    // Prediction and compare
    always_comb begin
        pred  = lfsr_next(prev);
        match = (word == pred) && (word != '0);
    end
endmodule

// File: rtl/lfsr_checker.sv
// LFSR sequence checker: hunts for lock on a run of correct predictions,
// then flags and counts mismatches until a run of errors drops lock.
// Optional statistics (err_count, clr_count, period_tick) are built only when
// LFSR_CHK_STATS_EN is defined; otherwise those outputs are tied to 0.
module lfsr_checker
    import lfsr_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED        = LFSR_SEED_DEFAULT,
    parameter int                LOCK_CNT    = 4,
    parameter int                UNLOCK_ERRS = 4,
    parameter int                ERR_W       = 16
) (
    input  logic           clk,
    input  logic           rst,
    lfsr_checker_if.slave  bus
);
    localparam logic [3:0] LOCK_CNT_C    = 4'(LOCK_CNT);
    localparam logic [3:0] UNLOCK_ERRS_C = 4'(UNLOCK_ERRS);

    chk_state_e        state_q, state_d;
    logic              have_prev_q, have_prev_d;
    logic [LFSR_W-1:0] prev_q, prev_d;
    logic [3:0]        good_run_q, good_run_d;
    logic [3:0]        bad_run_q, bad_run_d;
    logic              locked_q, locked_d;
    logic              err_pulse_q, err_pulse_d;

    logic              match;
    logic              check;
    logic              locked_err;
    logic              locked_match;

    lfsr_predict u_predict (
        .prev  (prev_q),
        .word  (bus.in_word),
        .match (match)
    );

    // Check qualifiers shared by the FSM and the statistics block
    always_comb begin
        check        = bus.in_valid && have_prev_q;
        locked_err   = check && (state_q == LOCKED) && !match;
        locked_match = check && (state_q == LOCKED) && match;
    end

    // Next-state: lock FSM, run counters, resync register
    always_comb begin
        state_d     = state_q;
        have_prev_d = have_prev_q;
        prev_d      = prev_q;
        good_run_d  = good_run_q;
        bad_run_d   = bad_run_q;
        err_pulse_d = 1'b0;

        // Always resync to the received word so a single slip costs one
        // or two mismatches rather than permanent loss of alignment.
        if (bus.in_valid) begin
            prev_d      = bus.in_word;
            have_prev_d = 1'b1;
        end

        if (check) begin
            case (state_q)
                HUNT: begin
                    if (match) begin
                        good_run_d = good_run_q + 4'd1;
                        if (good_run_d == LOCK_CNT_C) begin
                            state_d   = LOCKED;
                            bad_run_d = 4'd0;
                        end
                    end else begin
                        good_run_d = 4'd0;
                    end
                end
                LOCKED: begin
                    if (match) begin
                        bad_run_d = 4'd0;
                    end else begin
                        err_pulse_d = 1'b1;
                        bad_run_d   = bad_run_q + 4'd1;
                        if (bad_run_d == UNLOCK_ERRS_C) begin
                            state_d    = HUNT;
                            good_run_d = 4'd0;
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end

        locked_d = (state_d == LOCKED);
    end

    // Core registers with registered status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= HUNT;
            have_prev_q <= 1'b0;
            prev_q      <= '0;
            good_run_q  <= 4'd0;
            bad_run_q   <= 4'd0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            have_prev_q <= have_prev_d;
            prev_q      <= prev_d;
            good_run_q  <= good_run_d;
            bad_run_q   <= bad_run_d;
            locked_q    <= locked_d;
            err_pulse_q <= err_pulse_d;
        end
    end

    assign bus.locked    = locked_q;
    assign bus.err_pulse = err_pulse_q;

`ifdef LFSR_CHK_STATS_EN
    logic [ERR_W-1:0] err_count_q, err_count_d;
    logic             period_tick_q, period_tick_d;

    // Saturating error counter (clear wins) and seed-return marker
    always_comb begin
        err_count_d = err_count_q;
        if (locked_err && (err_count_q != '1)) begin
            err_count_d = err_count_q + ERR_W'(1);
        end
        if (bus.clr_count) begin
            err_count_d = '0;
        end
        period_tick_d = locked_match && (bus.in_word == SEED);
    end

    // Statistics registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count_q   <= '0;
            period_tick_q <= 1'b0;
        end else begin
            err_count_q   <= err_count_d;
            period_tick_q <= period_tick_d;
        end
    end

    assign bus.err_count   = err_count_q;
    assign bus.period_tick = period_tick_q;
`else
    logic unused_stats;

    assign bus.err_count   = '0;
    assign bus.period_tick = 1'b0;
    assign unused_stats    = ^{bus.clr_count, locked_err, locked_match, SEED};
`endif

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed bench for lfsr_checker: table of single-word steps with
// hand-computed expectations, then saturation, mid-stream reset and a
// full-period run. Statistic expectations collapse to 0 when
// LFSR_CHK_STATS_EN is not defined.
module tb_lfsr_checker;

`ifdef LFSR_CHK_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif
    localparam logic [15:0] SEED  = 16'h026E;
    localparam int          ERR_W = 4;
    localparam int          CMAX  = 15;

    // Word kinds: 0 clean stream word, 1 zero replaces stream word,
    // 2 stream word with bit 0 flipped, 3 literal word (stream restarts after it)
    typedef struct {
        bit          v;
        int          kind;
        logic [15:0] w;
        bit          clr;
        bit          e_lock;
        bit          e_pulse;
        int          e_cnt;
    } vec_t;

    logic clk;
    logic rst;
    lfsr_checker_if #(.ERR_W(ERR_W)) bus ();

    lfsr_checker #(
        .SEED        (SEED),
        .LOCK_CNT    (4),
        .UNLOCK_ERRS (4),
        .ERR_W       (ERR_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] g;
    vec_t        tbl[$];

    function automatic logic [15:0] nxt(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[14] ^ s[12] ^ s[3]};
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic drive(input bit v, input logic [15:0] w, input bit clr);
        bus.in_valid  = v;
        bus.in_word   = w;
        bus.clr_count = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input bit v, input int kind, input logic [15:0] w, input bit clr,
                       input bit el, input bit ep, input int ec);
        vec_t r;
        r.v = v; r.kind = kind; r.w = w; r.clr = clr;
        r.e_lock = el; r.e_pulse = ep; r.e_cnt = ec;
        tbl.push_back(r);
    endtask

    // Produce the next word of the given kind and advance the stream
    task automatic next_word(input int kind, input logic [15:0] lit, output logic [15:0] w);
        case (kind)
            1:       begin w = 16'h0000;   g = nxt(g);   end
            2:       begin w = g ^ 16'h1;  g = nxt(g);   end
            3:       begin w = lit;        g = nxt(lit); end
            default: begin w = g;          g = nxt(g);   end
        endcase
    endtask

    initial begin
        logic [15:0] w;
        int e;
        int tick_bad, pulses, drops, ticks, seeds;

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_word   = 16'h0;
        bus.clr_count = 1'b0;
        g             = SEED;

        //  v  kind word      clr lock pulse cnt
        add(1, 3, 16'h026E, 0, 0, 0, 0);   // first word: no check
        add(1, 3, 16'h04DD, 0, 0, 0, 0);
        add(1, 3, 16'h09BB, 0, 0, 0, 0);
        add(1, 3, 16'h1377, 0, 0, 0, 0);
        add(1, 3, 16'h26EF, 0, 1, 0, 0);   // 4th match locks
        add(1, 0, 16'h0,    0, 1, 0, 0);
        add(1, 1, 16'h0,    0, 1, 1, 1);   // zero word
        add(1, 0, 16'h0,    0, 1, 1, 2);   // resync from zero mismatches
        add(1, 0, 16'h0,    0, 1, 0, 2);
        add(1, 0, 16'h0,    0, 1, 0, 2);
        add(0, 0, 16'h0,    0, 1, 0, 2);   // idle cycle
        add(1, 2, 16'h0,    0, 1, 1, 3);   // four corrupted words
        add(1, 2, 16'h0,    0, 1, 1, 4);
        add(1, 2, 16'h0,    0, 1, 1, 5);
        add(1, 2, 16'h0,    0, 0, 1, 6);   // 4th drops lock, still counted
        add(1, 0, 16'h0,    0, 0, 0, 6);   // resync mismatch in HUNT: silent
        add(1, 0, 16'h0,    0, 0, 0, 6);
        add(1, 0, 16'h0,    0, 0, 0, 6);
        add(1, 0, 16'h0,    0, 0, 0, 6);
        add(1, 0, 16'h0,    0, 1, 0, 6);   // relock after 4 matches
        add(1, 2, 16'h0,    1, 1, 1, 0);   // clear wins over counted error
        add(1, 0, 16'h0,    0, 1, 1, 1);
        add(1, 0, 16'h0,    1, 1, 0, 0);   // plain clear
        add(1, 0, 16'h0,    0, 1, 0, 0);

        repeat (2) @(posedge clk);
        #1;
        chk("reset_locked", int'(bus.locked), 0);
        chk("reset_err_pulse", int'(bus.err_pulse), 0);
        chk("reset_err_count", int'(bus.err_count), 0);
        chk("reset_period_tick", int'(bus.period_tick), 0);
        @(negedge clk);
        rst = 1'b0;

        foreach (tbl[i]) begin
            if (tbl[i].v) next_word(tbl[i].kind, tbl[i].w, w);
            else          w = 16'h0;
            drive(tbl[i].v, w, tbl[i].clr);
            $display("row %0d valid %0d word %h locked %0d pulse %0d count %0d tick %0d",
                     i, tbl[i].v, w, bus.locked, bus.err_pulse, bus.err_count, bus.period_tick);
            chk($sformatf("row%0d_locked", i), int'(bus.locked), int'(tbl[i].e_lock));
            chk($sformatf("row%0d_err_pulse", i), int'(bus.err_pulse), int'(tbl[i].e_pulse));
            chk($sformatf("row%0d_err_count", i), int'(bus.err_count), STATS ? tbl[i].e_cnt : 0);
            chk($sformatf("row%0d_period_tick", i), int'(bus.period_tick), 0);
        end

        // Saturation: each zero word costs two errors, two clean words recover
        e = 0;
        for (int k = 1; k <= 8; k++) begin
            next_word(1, 16'h0, w);
            drive(1'b1, w, 1'b0);
            e = (e < CMAX) ? e + 1 : CMAX;
            $display("sat %0d zero word locked %0d pulse %0d count %0d", k, bus.locked, bus.err_pulse, bus.err_count);
            chk("sat_zero_pulse", int'(bus.err_pulse), 1);
            chk("sat_zero_count", int'(bus.err_count), STATS ? e : 0);
            next_word(0, 16'h0, w);
            drive(1'b1, w, 1'b0);
            e = (e < CMAX) ? e + 1 : CMAX;
            chk("sat_resync_count", int'(bus.err_count), STATS ? e : 0);
            next_word(0, 16'h0, w);
            drive(1'b1, w, 1'b0);
            $display("sat %0d clean word locked %0d pulse %0d count %0d", k, bus.locked, bus.err_pulse, bus.err_count);
            chk("sat_clean_pulse", int'(bus.err_pulse), 0);
            chk("sat_locked", int'(bus.locked), 1);
        end

        // Asynchronous reset while locked with a pulse and a full count pending
        next_word(1, 16'h0, w);
        drive(1'b1, w, 1'b0);
        chk("prerst_pulse", int'(bus.err_pulse), 1);
        chk("prerst_count", int'(bus.err_count), STATS ? CMAX : 0);
        #2;
        rst = 1'b1;
        #1;
        $display("async reset locked %0d pulse %0d count %0d tick %0d", bus.locked, bus.err_pulse, bus.err_count, bus.period_tick);
        chk("rst_locked", int'(bus.locked), 0);
        chk("rst_err_pulse", int'(bus.err_pulse), 0);
        chk("rst_err_count", int'(bus.err_count), 0);
        chk("rst_period_tick", int'(bus.period_tick), 0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            next_word(0, 16'h0, w);
            drive(1'b1, w, 1'b0);
            $display("post-reset word %0d %h locked %0d pulse %0d", k, w, bus.locked, bus.err_pulse);
            chk($sformatf("relock%0d_locked", k), int'(bus.locked), (k == 5) ? 1 : 0);
            chk($sformatf("relock%0d_pulse", k), int'(bus.err_pulse), 0);
        end

        // Full period while locked: one tick per SEED word, no errors
        tick_bad = 0; pulses = 0; drops = 0; ticks = 0; seeds = 0;
        for (int k = 0; k < 65540; k++) begin
            next_word(0, 16'h0, w);
            drive(1'b1, w, 1'b0);
            if (bus.period_tick !== (STATS && (w == SEED))) tick_bad++;
            if (bus.err_pulse) pulses++;
            if (!bus.locked) drops++;
            if (bus.period_tick) ticks++;
            if (w == SEED) seeds++;
        end
        $display("period run seeds %0d ticks %0d pulses %0d drops %0d", seeds, ticks, pulses, drops);
        chk("period_tick_misplaced", tick_bad, 0);
        chk("period_err_pulses", pulses, 0);
        chk("period_lock_drops", drops, 0);
        chk("period_tick_total", ticks, STATS ? seeds : 0);
        chk("period_err_count", int'(bus.err_count), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
